// File: rtl/sort_data_loader.sv
// Batch generator for the sorter: streams N Galois-LFSR words over valid/ready,
// pulses sort_start after the last word, then waits for sort_done.
module sort_data_loader #(
   parameter int                DATA_W = 8,
   parameter int                N      = 8,
   parameter logic [DATA_W-1:0] SEED   = 'hA5,
   parameter logic [DATA_W-1:0] TAPS   = 'hB8,
   localparam int               IDX_W  = (N > 1) ? $clog2(N) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_go,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [IDX_W-1:0]  o_out_idx,
   output logic              o_sort_start,
   input  logic              i_sort_done,
   output logic              o_busy,
   output logic [7:0]        o_batch_cnt
);

   localparam logic [DATA_W-1:0] SEED_EFF = (SEED == '0) ? DATA_W'(1) : SEED;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

   typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

   state_t              r_state, w_state_nxt;
   logic [DATA_W-1:0]   r_lfsr;
   logic [IDX_W-1:0]    r_idx;
   logic [7:0]          r_batch_cnt;
   logic                w_xfer;
   logic [DATA_W-1:0]   w_lfsr_nxt;

   assign w_xfer     = (r_state == LOAD) && i_out_ready;
   assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_lfsr      <= SEED_EFF;
         r_idx       <= '0;
         r_batch_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         // idx wraps to 0 on the last transfer so the next batch starts clean
         if (w_xfer) begin
            r_lfsr <= w_lfsr_nxt;
            r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
         end
         if (r_state == WAIT && i_sort_done)
            r_batch_cnt <= r_batch_cnt + 8'd1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_go) w_state_nxt = LOAD;
         LOAD:    if (w_xfer && r_idx == LAST_IDX) w_state_nxt = START;
         START:   w_state_nxt = WAIT;
         WAIT:    if (i_sort_done) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from state only, never from i_out_ready.
   assign o_out_valid  = (r_state == LOAD);
   assign o_out_data   = (r_state == LOAD) ? r_lfsr : '0;
   assign o_out_idx    = (r_state == LOAD) ? r_idx : '0;
   assign o_sort_start = (r_state == START);
   assign o_busy       = (r_state != IDLE);
   assign o_batch_cnt  = r_batch_cnt;

endmodule

// File: tb/tb_sort_data_loader.sv
// Directed bench for sort_data_loader; transfers are checked by a queue-based
// monitor, control timing is checked inline by the driver.
module tb_sort_data_loader;

   logic       clk = 1'b0;
   logic       rst, go, out_ready, sort_done;
   logic       out_valid, sort_start, busy;
   logic [7:0] out_data, batch_cnt;
   logic [2:0] out_idx;

   int checks = 0;
   int errors = 0;
   logic [10:0] q [$];

   logic [7:0] seq_a [8] = '{8'hA5, 8'hEA, 8'h75, 8'h82, 8'h41, 8'h98, 8'h4C, 8'h26};
   logic [7:0] seq_b [8] = '{8'h13, 8'hB1, 8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07};
   logic [7:0] seq_c [8] = '{8'hBB, 8'hE5, 8'hCA, 8'h65, 8'h8A, 8'h00, 8'h00, 8'h00};

   sort_data_loader dut (
      .i_clk(clk), .i_rst(rst), .i_go(go),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_data(out_data), .o_out_idx(out_idx),
      .o_sort_start(sort_start), .i_sort_done(sort_done),
      .o_busy(busy), .o_batch_cnt(batch_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: every transfer pops one expected {idx,data}
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_xfer_idx", {29'd0, out_idx}, 32'hFFFF);
         end else begin
            logic [10:0] e;
            e = q.pop_front();
            chk("xfer_data", {24'd0, out_data}, {24'd0, e[7:0]});
            chk("xfer_idx", {29'd0, out_idx}, {29'd0, e[10:8]});
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] s [8], input int n);
      for (int i = 0; i < n; i++) q.push_back({i[2:0], s[i]});
   endtask

   task automatic wait_idx(input int k);
      bit found = 0;
      for (int c = 0; c < 60 && !found; c++) begin
         @(negedge clk);
         if (out_valid && out_ready && out_idx == k[2:0]) found = 1;
      end
      if (!found) chk("timeout_wait_idx", 32'd0, k);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; go = 0; out_ready = 1; sort_done = 0;
      tick; tick;
      chk("rst_valid", out_valid, 0);
      chk("rst_start", sort_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", out_data, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_cnt", batch_cnt, 0);
      rst = 0;

      // sort_done in IDLE is ignored
      sort_done = 1; tick; sort_done = 0;
      chk("idle_done_cnt", batch_cnt, 0);
      chk("idle_done_busy", busy, 0);

      // batch 1, ready high, go/done noise during LOAD
      push(seq_a, 8);
      go = 1; tick; go = 0;
      chk("lat_valid", out_valid, 1);
      chk("lat_data", out_data, 8'hA5);
      chk("lat_idx", out_idx, 0);
      wait_idx(3); tick;
      go = 1; sort_done = 1; tick; go = 0; sort_done = 0;
      chk("load_noise_busy", busy, 1);
      chk("load_noise_cnt", batch_cnt, 0);
      wait_idx(7); tick;
      chk("b1_start", sort_start, 1);
      chk("b1_valid_drop", out_valid, 0);
      tick;
      chk("b1_start_once", sort_start, 0);
      chk("b1_wait_busy", busy, 1);
      go = 1; tick; go = 0; tick;
      chk("wait_go_busy", busy, 1);
      chk("wait_go_valid", out_valid, 0);
      sort_done = 1; tick; sort_done = 0;
      chk("b1_done_busy", busy, 0);
      chk("b1_cnt", batch_cnt, 1);

      // batch 2 continues the LFSR; go+done together in WAIT
      push(seq_b, 8);
      go = 1; tick; go = 0;
      wait_idx(7); tick;
      chk("b2_start", sort_start, 1);
      tick;
      go = 1; sort_done = 1; tick; go = 0; sort_done = 0;
      chk("godone_busy", busy, 0);
      chk("b2_cnt", batch_cnt, 2);
      tick; tick;
      chk("godone_stay_idle", busy, 0);
      chk("godone_no_valid", out_valid, 0);

      // batch 3 aborted by reset while idx 4 is presented
      push(seq_c, 4);
      go = 1; tick; go = 0;
      wait_idx(3); tick;
      chk("abort_pre_idx", out_idx, 4);
      chk("abort_pre_data", out_data, 8'h8A);
      rst = 1; out_ready = 0; tick;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_cnt", batch_cnt, 0);
      rst = 0; out_ready = 1;

      // batch 4 restarts at A5, with backpressure at idx 2
      push(seq_a, 8);
      go = 1; tick; go = 0;
      begin
         bit hit = 0;
         for (int c = 0; c < 20 && !hit; c++) begin
            if (out_valid && out_idx == 3'd2) hit = 1;
            else tick;
         end
         if (!hit) chk("timeout_idx2", 32'd0, 2);
      end
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, 8'h75);
         chk("bp_idx", out_idx, 2);
      end
      out_ready = 1;
      wait_idx(7); tick;
      chk("b4_start", sort_start, 1);
      sort_done = 1; tick;
      chk("start_done_ignored", batch_cnt, 0);
      tick; sort_done = 0;
      chk("b4_cnt", batch_cnt, 1);
      chk("b4_idle", busy, 0);
      tick; tick;
      chk("queue_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
